// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit: op encoding and FSM states.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101,
        MDU_NOP0  = 3'b110,
        MDU_NOP1  = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIN  = 2'b11
    } mdu_state_t;

    localparam mdu_op_t OP_MULT  = MDU_MULT;
    localparam mdu_op_t OP_MULTU = MDU_MULTU;
    localparam mdu_op_t OP_DIV   = MDU_DIV;
    localparam mdu_op_t OP_DIVU  = MDU_DIVU;
    localparam mdu_op_t OP_MTHI  = MDU_MTHI;
    localparam mdu_op_t OP_MTLO  = MDU_MTLO;

endpackage

// File: rtl/muldiv_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; one quotient bit
// per cycle after start, with last flagging the final iteration.
module muldiv_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic             run_r;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_nxt_s;
    logic [WIDTH-1:0] quo_nxt_s;

    // Trial subtraction; a borrow in the top bit means restore the shifted remainder.
    always_comb begin
        trial_s = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvs_r};
        if (trial_s[WIDTH]) begin
            rem_nxt_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
        end else begin
            rem_nxt_s = trial_s[WIDTH-1:0];
        end
        quo_nxt_s = {quo_r[WIDTH-2:0], ~trial_s[WIDTH]};
    end

    // Iteration registers: load on start, step while running, then hold results.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_r <= {WIDTH{1'b0}};
            quo_r <= {WIDTH{1'b0}};
            dvs_r <= {WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            run_r <= 1'b0;
        end else if (start) begin
            rem_r <= {WIDTH{1'b0}};
            quo_r <= dividend;
            dvs_r <= divisor;
            cnt_r <= {CNT_W{1'b0}};
            run_r <= 1'b1;
        end else if (run_r) begin
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            cnt_r <= cnt_r + CNT_ONE;
            run_r <= (cnt_r != CNT_LAST);
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;
    assign last      = run_r && (cnt_r == CNT_LAST);

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Define MULDIV_FAST_MUL_EN for a
// single-cycle combinational multiply; divide stays iterative either way.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_t         state_r;
    mdu_state_t         state_nxt_s;
    mdu_op_t            op_s;
    logic               accept_s;
    logic               is_mul_s;
    logic               is_div_s;
    logic               sgn_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_step_s;
    logic [2*WIDTH-1:0] prod_fin_s;
    logic [WIDTH-1:0]   quo_fin_s;
    logic [WIDTH-1:0]   rem_fin_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;
    logic [WIDTH-1:0]   div_quo_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic               div_last_s;

    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [WIDTH-1:0]   mcand_r;
    logic               neg_r;
    logic               rneg_r;
    logic               dbz_r;
    logic               is_div_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;
    logic               busy_r;

    assign op_s     = mdu_op_t'(op);
    assign ready_o  = (state_r == ST_IDLE);
    assign accept_s = valid_i && ready_o && !flush;

    // Opcode decode into multiply/divide class and signedness.
    always_comb begin
        is_mul_s = 1'b0;
        is_div_s = 1'b0;
        sgn_s    = 1'b0;
        case (op_s)
            OP_MULT:  begin is_mul_s = 1'b1; sgn_s = 1'b1; end
            OP_MULTU: begin is_mul_s = 1'b1; end
            OP_DIV:   begin is_div_s = 1'b1; sgn_s = 1'b1; end
            OP_DIVU:  begin is_div_s = 1'b1; end
            default:  begin is_mul_s = 1'b0; end
        endcase
    end

    assign a_mag_s = (sgn_s && srca[WIDTH-1]) ? -srca : srca;
    assign b_mag_s = (sgn_s && srcb[WIDTH-1]) ? -srcb : srcb;

    // Shift-add step: low half holds the remaining multiplier bits.
    assign mul_sum_s  = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                      + (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    assign mul_step_s = {mul_sum_s, prod_r[WIDTH-1:1]};

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod_s;
    // Sign- or zero-extend to 2*WIDTH; the truncated product is then exact for both.
    always_comb begin
        if (sgn_s) begin
            fast_prod_s = {{WIDTH{srca[WIDTH-1]}}, srca} * {{WIDTH{srcb[WIDTH-1]}}, srcb};
        end else begin
            fast_prod_s = {{WIDTH{1'b0}}, srca} * {{WIDTH{1'b0}}, srcb};
        end
    end
`endif

    muldiv_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (accept_s && is_div_s),
        .dividend  (a_mag_s),
        .divisor   (b_mag_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s),
        .last      (div_last_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush cancels any in-flight operation.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nxt_s = ST_FIN;
`else
                    state_nxt_s = ST_MUL;
`endif
                end else if (accept_s && is_div_s) begin
                    state_nxt_s = ST_DIV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (div_last_s) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_FIN:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand capture at accept and multiplier iteration.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r    <= {CNT_W{1'b0}};
            prod_r   <= {(2*WIDTH){1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            neg_r    <= 1'b0;
            rneg_r   <= 1'b0;
            dbz_r    <= 1'b0;
            is_div_r <= 1'b0;
            a_r      <= {WIDTH{1'b0}};
        end else if (accept_s && is_mul_s) begin
`ifdef MULDIV_FAST_MUL_EN
            prod_r   <= fast_prod_s;
            neg_r    <= 1'b0;
`else
            prod_r   <= {{WIDTH{1'b0}}, b_mag_s};
            neg_r    <= sgn_s && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
`endif
            mcand_r  <= a_mag_s;
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= 1'b0;
            dbz_r    <= 1'b0;
        end else if (accept_s && is_div_s) begin
            neg_r    <= sgn_s && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            rneg_r   <= sgn_s && srca[WIDTH-1];
            dbz_r    <= (srcb == {WIDTH{1'b0}});
            a_r      <= srca;
            is_div_r <= 1'b1;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (state_r == ST_MUL) begin
            prod_r   <= mul_step_s;
            cnt_r    <= cnt_r + CNT_ONE;
        end
    end

    // Final sign fix-up; divide-by-zero overrides the iterated result.
    always_comb begin
        prod_fin_s = neg_r  ? -prod_r    : prod_r;
        quo_fin_s  = neg_r  ? -div_quo_s : div_quo_s;
        rem_fin_s  = rneg_r ? -div_rem_s : div_rem_s;
        if (!is_div_r) begin
            res_hi_s = prod_fin_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_fin_s[WIDTH-1:0];
        end else if (dbz_r) begin
            res_hi_s = a_r;
            res_lo_s = {WIDTH{1'b1}};
        end else begin
            res_hi_s = rem_fin_s;
            res_lo_s = quo_fin_s;
        end
    end

    // Architectural HI/LO, done pulse and busy flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_nxt_s != ST_IDLE);
            if (accept_s && (op_s == OP_MTHI)) begin
                hi_r <= srca;
            end else if (accept_s && (op_s == OP_MTLO)) begin
                lo_r <= srca;
            end else if ((state_r == ST_FIN) && !flush) begin
                hi_r   <= res_hi_s;
                lo_r   <= res_lo_s;
                done_r <= 1'b1;
            end
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign done = done_r;
    assign busy = busy_r;

endmodule
